reg_bank_param: RTL and testbench

REG_BANK_PARAM -- requirements
Module: reg_bank_param

---
 rtl/reg_bank_param.sv | 134 +++++++++++++
 tb/tb_reg_bank_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_param.sv
// Parameterised 32-bit register bank: latched register number, read-only and
// double-buffered registers, deferred shadow-to-live commit, and an error counter.
module reg_bank_param #(
  parameter int unsigned            NUM_REGS    = 64,
  parameter int unsigned            ADDR_W      = 6,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
  parameter logic [NUM_REGS-1:0]    SHADOW_MASK = '0,
  parameter logic [NUM_REGS*32-1:0] DEFAULTS    = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              rx_data,
  input  logic                     reg_num_le,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [31:0]              tx_data,
  output logic                     rd_valid,
  output logic                     illegal_reg_num,
  input  logic [NUM_REGS*32-1:0]   ro_data,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse,
  input  logic                     commit_req,
  input  logic                     acq_busy,
  output logic                     commit_done,
  output logic [7:0]               err_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, APPLY, DONE} state_e;

  state_e                state_q, state_d;
  logic [31:0]           reg_num_q, reg_num_d;
  logic [31:0]           shadow_q [NUM_REGS];
  logic [31:0]           shadow_d [NUM_REGS];
  logic [31:0]           live_q   [NUM_REGS];
  logic [31:0]           live_d   [NUM_REGS];
  logic [31:0]           tx_data_q, tx_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic                  commit_done_q, commit_done_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [ADDR_W-1:0]     idx;
  logic                  is_ro;
  logic                  wr_ok;
  logic                  err_hit;

  assign idx             = reg_num_q[ADDR_W-1:0];
  assign illegal_reg_num = (reg_num_q >= NUM_REGS);
  assign is_ro           = RO_MASK[idx];
  assign wr_ok           = wr_en & ~illegal_reg_num & ~is_ro;
  // A simultaneous read+write to an illegal number is one rejected access.
  assign err_hit         = ((wr_en | rd_en) & illegal_reg_num) |
                           (wr_en & ~illegal_reg_num & is_ro);

  always_comb begin
    state_d       = state_q;
    commit_done_d = 1'b0;
    case (state_q)
      IDLE:  if (commit_req) state_d = WAIT;
      WAIT:  if (!acq_busy)  state_d = APPLY;
      APPLY: state_d = DONE;
      DONE: begin
        state_d       = IDLE;
        commit_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_num_d  = reg_num_le ? rx_data : reg_num_q;
    tx_data_d  = tx_data_q;
    rd_valid_d = rd_en;
    wr_pulse_d = '0;
    err_cnt_d  = err_cnt_q;
    if (rd_en) begin
      if (illegal_reg_num)  tx_data_d = 32'hDEAD_BEEF;
      else if (is_ro)       tx_data_d = ro_data[{idx, 5'd0} +: 32];
      else                  tx_data_d = live_q[idx];
    end
    if (err_hit && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    // Commit copies the pre-edge shadow, so a write on the APPLY edge only reaches the shadow.
    for (int unsigned n = 0; n < NUM_REGS; n++) begin
      shadow_d[n] = shadow_q[n];
      live_d[n]   = live_q[n];
      if ((state_q == APPLY) && SHADOW_MASK[n]) live_d[n] = shadow_q[n];
      if (wr_ok && (idx == ADDR_W'(n))) begin
        shadow_d[n]   = rx_data;
        wr_pulse_d[n] = 1'b1;
        if (!SHADOW_MASK[n]) live_d[n] = rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      reg_num_q     <= '0;
      tx_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      wr_pulse_q    <= '0;
      commit_done_q <= 1'b0;
      err_cnt_q     <= '0;
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
        shadow_q[n] <= DEFAULTS[n*32 +: 32];
        live_q[n]   <= DEFAULTS[n*32 +: 32];
      end
    end else begin
      state_q       <= state_d;
      reg_num_q     <= reg_num_d;
      tx_data_q     <= tx_data_d;
      rd_valid_q    <= rd_valid_d;
      wr_pulse_q    <= wr_pulse_d;
      commit_done_q <= commit_done_d;
      err_cnt_q     <= err_cnt_d;
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
        shadow_q[n] <= shadow_d[n];
        live_q[n]   <= live_d[n];
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int unsigned n = 0; n < NUM_REGS; n++) reg_q[n*32 +: 32] = live_q[n];
  end

  assign tx_data     = tx_data_q;
  assign rd_valid    = rd_valid_q;
  assign wr_pulse    = wr_pulse_q;
  assign commit_done = commit_done_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_reg_bank_param.sv
// Randomised scoreboard bench for reg_bank_param: reads are predicted into a
// queue by a register-array model and popped by a monitor on rd_valid.
module tb_reg_bank_param;
  localparam int unsigned      NR   = 64;
  localparam logic [NR-1:0]    RO   = 64'h0000_0000_0010_0080;
  localparam logic [NR-1:0]    SH   = 64'h0000_0100_0000_0C00;
  localparam logic [NR*32-1:0] DEFS = ((NR*32)'(32'd70000)       << (2*32))  |
                                      ((NR*32)'(32'h7777_0007)   << (7*32))  |
                                      ((NR*32)'(32'h0000_0AAA)   << (10*32)) |
                                      ((NR*32)'(32'h5555_0028)   << (40*32));

  logic              clk = 1'b0;
  logic              reset, reg_num_le, wr_en, rd_en, commit_req, acq_busy;
  logic [31:0]       rx_data, tx_data;
  logic              rd_valid, illegal_reg_num, commit_done;
  logic [NR*32-1:0]  ro_data, reg_q;
  logic [NR-1:0]     wr_pulse;
  logic [7:0]        err_cnt;

  always #5 clk = ~clk;

  reg_bank_param #(.NUM_REGS(NR), .ADDR_W(6), .RO_MASK(RO), .SHADOW_MASK(SH), .DEFAULTS(DEFS)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .reg_num_le(reg_num_le), .wr_en(wr_en),
    .rd_en(rd_en), .tx_data(tx_data), .rd_valid(rd_valid), .illegal_reg_num(illegal_reg_num),
    .ro_data(ro_data), .reg_q(reg_q), .wr_pulse(wr_pulse), .commit_req(commit_req),
    .acq_busy(acq_busy), .commit_done(commit_done), .err_cnt(err_cnt));

  logic [NR-1:0]    ro_v, sh_v;
  logic [NR*32-1:0] defs_v;
  logic [31:0]      shadow_m [NR];
  logic [31:0]      live_m   [NR];
  logic [31:0]      rov      [NR];
  logic [31:0]      rnum_m;
  int               err_m;
  logic [31:0]      rd_exp_q [$];
  logic [31:0]      mon_exp;
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regq(input string name);
    int bad = -1;
    n_checks++;
    for (int n = 0; n < NR; n++)
      if (bad < 0 && reg_q[32*n +: 32] !== live_m[n]) bad = n;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: reg_q[%0d] got %h expected %h", name, bad, reg_q[32*bad +: 32], live_m[bad]);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NR; n++) begin
      shadow_m[n] = defs_v[32*n +: 32];
      live_m[n]   = defs_v[32*n +: 32];
    end
    err_m  = 0;
    rnum_m = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [31:0] n);
    reg_num_le = 1'b1;
    rx_data    = n;
    cycle();
    reg_num_le = 1'b0;
    rnum_m     = n;
    check("illegal_reg_num", 64'(illegal_reg_num), 64'(rnum_m >= NR));
  endtask

  // One access cycle; read expectation is pushed before the write takes effect.
  task automatic access(input bit wr, input bit rd, input logic [31:0] d);
    bit          ill = (rnum_m >= NR);
    int unsigned n   = rnum_m[5:0];
    bit          ro  = ro_v[n];
    logic [NR-1:0] exp_pulse = '0;
    if (rd) rd_exp_q.push_back(ill ? 32'hDEAD_BEEF : (ro ? rov[n] : live_m[n]));
    if ((((wr || rd) && ill) || (wr && !ill && ro)) && err_m < 255) err_m++;
    wr_en = wr; rd_en = rd; rx_data = d;
    cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    if (wr && !ill && !ro) begin
      shadow_m[n]  = d;
      if (!sh_v[n]) live_m[n] = d;
      exp_pulse[n] = 1'b1;
    end
    check("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
    check("err_cnt", 64'(err_cnt), 64'(err_m));
    check_regq("reg_q_after_access");
  endtask

  task automatic commit(input int busy, input bit wr_apply, input logic [31:0] wd, input bit req_in_done);
    commit_req = 1'b1;
    acq_busy   = (busy > 0);
    cycle();
    commit_req = 1'b0;
    check_regq("commit_wait_entry");
    for (int i = 0; i < busy; i++) begin
      if (i == busy / 2) commit_req = 1'b1;
      cycle();
      commit_req = 1'b0;
      check_regq("commit_busy_hold");
      check("commit_done_busy", 64'(commit_done), 64'd0);
    end
    acq_busy = 1'b0;
    cycle();
    check_regq("commit_pre_apply");
    check("commit_done_pre", 64'(commit_done), 64'd0);
    if (wr_apply) begin wr_en = 1'b1; rx_data = wd; end
    cycle();
    wr_en = 1'b0;
    for (int n = 0; n < NR; n++) if (sh_v[n]) live_m[n] = shadow_m[n];
    if (wr_apply && rnum_m < NR && !ro_v[rnum_m[5:0]]) begin
      shadow_m[rnum_m[5:0]] = wd;
      if (!sh_v[rnum_m[5:0]]) live_m[rnum_m[5:0]] = wd;
    end
    check_regq("commit_apply");
    check("commit_done_apply", 64'(commit_done), 64'd0);
    if (req_in_done) commit_req = 1'b1;
    cycle();
    commit_req = 1'b0;
    check("commit_done_pulse", 64'(commit_done), 64'd1);
    cycle();
    check("commit_done_low", 64'(commit_done), 64'd0);
    if (req_in_done)
      for (int i = 0; i < 4; i++) begin
        cycle();
        check("commit_not_queued", 64'(commit_done), 64'd0);
      end
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      n_checks++;
      if (rd_exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_valid_unexpected: got tx_data %h expected no rd_valid", tx_data);
      end else begin
        mon_exp = rd_exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_data: got %h expected %h", tx_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ro_v = RO; sh_v = SH; defs_v = DEFS;
    for (int n = 0; n < NR; n++) begin
      rov[n] = $urandom;
      if (n == 7) rov[n] = 32'hCAFE_0001;
      ro_data[32*n +: 32] = rov[n];
    end
    reset = 1'b1; reg_num_le = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    commit_req = 1'b0; acq_busy = 1'b0; rx_data = 32'h1234_5678;
    cycle(); cycle();
    reset = 1'b0;
    model_reset();
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    check("rst_commit_done", 64'(commit_done), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_illegal", 64'(illegal_reg_num), 64'd0);
    check_regq("rst_reg_q");

    latch(2);  access(0, 1, 0);
    latch(64); access(1, 0, 5); access(0, 1, 0);
    check("illegal_err_cnt", 64'(err_cnt), 64'd2);
    latch(7);  access(1, 0, 0); access(0, 1, 0);
    latch(3);  access(1, 1, 32'h1111_1111); access(1, 1, 32'h2222_2222); access(0, 1, 0);
    latch(10); access(1, 0, 32'h0000_1234);
    commit(0, 1'b0, '0, 1'b1);
    latch(40); access(1, 0, 32'hABCD_0040);
    commit(100, 1'b0, '0, 1'b0);
    latch(11); access(1, 0, 32'hAAAA_0011);
    commit(0, 1'b1, 32'hBBBB_0011, 1'b0);
    commit(2, 1'b0, '0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int unsigned op = $urandom_range(0, 19);
      if (op < 4)       latch(($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, NR-1)) : $urandom);
      else if (op < 10) access(1, 0, $urandom);
      else if (op < 15) access(0, 1, 0);
      else if (op < 18) access(1, 1, $urandom);
      else if (op < 19) latch(32'($urandom_range(9, 12)));
      else              commit($urandom_range(0, 3), 1'b0, '0, 1'b0);
    end

    latch(200);
    for (int i = 0; i < 300; i++) access(1, 0, $urandom);
    check("err_cnt_saturated", 64'(err_cnt), 64'd255);

    latch(10); access(1, 0, 32'h0BAD_0010);
    commit_req = 1'b1; acq_busy = 1'b1;
    cycle(); commit_req = 1'b0; cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; acq_busy = 1'b0;
    model_reset();
    check_regq("reset_in_wait_reg_q");
    check("reset_in_wait_err_cnt", 64'(err_cnt), 64'd0);
    check("reset_in_wait_tx_data", 64'(tx_data), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("reset_abort_commit_done", 64'(commit_done), 64'd0);
      check_regq("reset_abort_reg_q");
    end
    latch(10); access(0, 1, 0);
    cycle(); cycle();
    check("read_queue_drained", 64'(rd_exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
